// File: rtl/game_ctrl_if.sv
// Button, collision and status bundle between the game logic and game_ctrl.
// The slave side is the controller; the master side drives buttons and collide.
interface game_ctrl_if;
    logic       btn_start;
    logic       btn_speed;
    logic       collide;
    logic       gameover;
    logic       speed;
    logic       score_clr;
    logic [1:0] state;

    modport master (
        output btn_start, btn_speed, collide,
        input  gameover, speed, score_clr, state
    );

    modport slave (
        input  btn_start, btn_speed, collide,
        output gameover, speed, score_clr, state
    );
endinterface

// File: rtl/game_ctrl.sv
// Game controller: synchronized/debounced buttons driving an IDLE/RUN/OVER FSM.
// Optional macro AUTO_SPEEDUP_EN forces fast speed after SPEEDUP_CYCLES in RUN.
module game_ctrl #(
    parameter int unsigned DB_MAX         = 1000000,
    parameter int unsigned SPEEDUP_CYCLES = 500000000
) (
    input  logic        clk,
    input  logic        rst,
    game_ctrl_if.slave  io
);
    localparam int unsigned DBW = $clog2(DB_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_OVER = 2'b10
    } state_e;

    logic [1:0]     raw;
    logic [1:0]     sync1_q;
    logic [1:0]     sync2_q;
    logic [1:0]     db_q;
    logic [1:0]     dbp_q;
    logic [DBW-1:0] db_cnt_q [2];
    logic [DBW-1:0] db_cnt_d [2];
    logic           start_press;
    logic           speed_press;
    logic           sp_hit;

    state_e state_q;
    logic   gameover_q;
    logic   speed_q;
    logic   clr_q;

    // bit 0 = start, bit 1 = speed
    assign raw = {io.btn_speed, io.btn_start};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i] &&
                db_cnt_q[i] != DBW'(DB_MAX - 1)) begin
                db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            dbp_q   <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            dbp_q   <= db_q;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
                if (sync2_q[i] != db_q[i] &&
                    db_cnt_q[i] == DBW'(DB_MAX - 1)) begin
                    db_q[i] <= sync2_q[i];
                end
            end
        end
    end

    assign start_press = db_q[0] & ~dbp_q[0];
    assign speed_press = db_q[1] & ~dbp_q[1];

`ifdef AUTO_SPEEDUP_EN
    localparam int unsigned SPW = $clog2(SPEEDUP_CYCLES + 1);
    localparam logic [SPW-1:0] SP_LAST = SPW'(SPEEDUP_CYCLES - 1);

    logic [SPW-1:0] sp_cnt_q;

    assign sp_hit = (state_q == S_RUN) && (sp_cnt_q == SP_LAST);

    // Cleared on RUN entry, counts while in RUN, saturates at SP_LAST.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_cnt_q <= '0;
        end else if (state_q != S_RUN) begin
            if (start_press) begin
                sp_cnt_q <= '0;
            end
        end else if (sp_cnt_q != SP_LAST) begin
            sp_cnt_q <= sp_cnt_q + 1'b1;
        end
    end
`else
    logic unused_speedup;

    assign sp_hit         = 1'b0;
    assign unused_speedup = ^SPEEDUP_CYCLES;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            gameover_q <= 1'b1;
            speed_q    <= 1'b0;
            clr_q      <= 1'b0;
        end else begin
            clr_q <= 1'b0;
            unique case (state_q)
                S_IDLE, S_OVER: begin
                    if (start_press) begin
                        state_q    <= S_RUN;
                        gameover_q <= 1'b0;
                        clr_q      <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (io.collide) begin
                        state_q    <= S_OVER;
                        gameover_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    gameover_q <= 1'b1;
                end
            endcase
            if (speed_press && state_q != S_RUN) begin
                speed_q <= ~speed_q;
            end else if (sp_hit) begin
                speed_q <= 1'b1;
            end
        end
    end

    assign io.state     = state_q;
    assign io.gameover  = gameover_q;
    assign io.speed     = speed_q;
    assign io.score_clr = clr_q;
endmodule
